scan_seq: RTL

SCAN_SEQ -- requirements
Module: scan_seq

---
 rtl/scan_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/scan_seq.sv
// Channel scan sequencer: walks the enabled channels of a latched mask, holding
// each on the downstream decoder for dwell+1 cycles, single-shot or continuous.
module scan_seq #(
  parameter int NCH = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           stop,
  input  logic           cont,
  input  logic [NCH-1:0] mask,
  input  logic [3:0]     dwell,
  output logic [2:0]     sel,
  output logic           dec_off,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam logic [2:0] LAST = 3'(NCH - 1);

  typedef enum logic [1:0] {IDLE, SEEK, DWELL} state_t;

  state_t         state, nstate;
  logic [2:0]     ptr;
  logic [3:0]     cnt;
  logic [NCH-1:0] mask_q;
  logic [3:0]     dwell_q;

  logic hit, last, eos, wrap_go;

  assign hit     = mask_q[ptr];
  assign last    = (ptr == LAST);
  // End of sweep: last channel either skipped or finished dwelling.
  assign eos     = ((state == SEEK) && !hit && last) ||
                   ((state == DWELL) && (cnt == '0) && last);
  assign wrap_go = cont && (mask != '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start && (mask != '0)) nstate = SEEK;
      SEEK:    if (hit)        nstate = DWELL;
               else if (last)  nstate = wrap_go ? SEEK : IDLE;
      DWELL:   if (cnt != '0)  nstate = DWELL;
               else if (last)  nstate = wrap_go ? SEEK : IDLE;
               else            nstate = SEEK;
      default: nstate = IDLE;
    endcase
    if (stop) nstate = IDLE;
  end

  always_comb begin
    sel     = (state == IDLE) ? 3'd0 : ptr;
    dec_off = (state != DWELL);
    busy    = (state != IDLE);
  end

  // Datapath: pointer, dwell counter, latched config and the one-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      cnt     <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (stop) begin
        ptr <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            if (mask != '0) begin
              mask_q  <= mask;
              dwell_q <= dwell;
              ptr     <= '0;
            end else begin
              err <= 1'b1;
            end
          end
          SEEK: begin
            if (hit)        cnt <= dwell_q;
            else if (!last) ptr <= ptr + 3'd1;
          end
          DWELL: begin
            if (cnt != '0)  cnt <= cnt - 4'd1;
            else if (!last) ptr <= ptr + 3'd1;
          end
          default: ;
        endcase
        if (eos) begin
          done <= 1'b1;
          if (cont) begin
            ptr     <= '0;
            mask_q  <= mask;
            dwell_q <= dwell;
            if (mask == '0) err <= 1'b1;
          end
        end
      end
    end
  end

endmodule
